// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte sources
module uart_tx_arbiter #(
    parameter int Nreq  = 4,
    parameter int Wdata = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Nreq-1:0]       REQ,
    input  logic [Nreq-1:0]       LOCK,
    input  logic [Nreq*Wdata-1:0] DIN,
    output logic [Nreq-1:0]       ACK,
    output logic [Nreq-1:0]       GRANT,
    output logic [Wdata-1:0]      TX_DATA,
    output logic                  TX_START,
    input  logic                  TX_BUSY
);

    localparam int PW = (Nreq > 1) ? $clog2(Nreq) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          locked;
    logic          miss;

    // Rotation step; written as a compare so non-power-of-two Nreq wraps to 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(Nreq - 1)) ? '0 : i + PW'(1);
    endfunction

    // The owner released its lock while we sat idle: rotate past it this cycle.
    logic          drop_lock;
    logic [PW-1:0] scan_base;
    assign drop_lock = locked && !LOCK[win];
    assign scan_base = drop_lock ? next_idx(win) : ptr;

    // Frame completion, either a real stop bit or a start the TX never took.
    logic frame_end;
    assign frame_end = ((state == WAIT_LO) && !TX_BUSY) ||
                       ((state == WAIT_HI) && !TX_BUSY && miss);

    // Winner search: locked owner only, otherwise first request from scan_base.
    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = scan_base;
        if (locked && !drop_lock) begin
            found = REQ[win];
            pick  = win;
        end else begin
            for (int k = 0; k < Nreq; k++) begin
                if (!found && REQ[idx]) begin
                    found = 1'b1;
                    pick  = idx;
                end
                idx = next_idx(idx);
            end
        end
    end

    logic [Nreq-1:0] pick_oh;
    assign pick_oh = Nreq'(1) << pick;

    // Arbitration FSM with registered grant, start pulse, ack and data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            locked   <= 1'b0;
            miss     <= 1'b0;
            GRANT    <= '0;
            ACK      <= '0;
            TX_START <= 1'b0;
            TX_DATA  <= '0;
        end else begin
            ACK      <= '0;
            TX_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop_lock) begin
                        locked <= 1'b0;
                        ptr    <= next_idx(win);
                        GRANT  <= '0;
                    end
                    if (!TX_BUSY && found) begin
                        win      <= pick;
                        GRANT    <= pick_oh;
                        TX_DATA  <= DIN[int'(pick)*Wdata +: Wdata];
                        TX_START <= 1'b1;
                        ACK      <= pick_oh;
                        state    <= START;
                    end
                end
                START: begin
                    miss  <= 1'b0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
                    end else if (miss) begin
                        state <= IDLE;
                    end else begin
                        miss <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A dropped start is closed out like a finished frame so the
            // rotation still advances and the next requester gets served.
            if (frame_end) begin
                if (LOCK[win]) begin
                    locked <= 1'b1;
                end else begin
                    locked <= 1'b0;
                    GRANT  <= '0;
                    ptr    <= next_idx(win);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (Nreq=4 and Nreq=3)
module tb_uart_tx_arbiter;

    localparam int FRAME = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic [3:0]  REQ_a = '0, LOCK_a = '0, ACK_a, GRANT_a;
    logic [31:0] DIN_a = '0;
    logic [7:0]  TX_DATA_a;
    logic        TX_START_a, TX_BUSY_a;

    logic [2:0]  REQ_b = '0, LOCK_b = '0, ACK_b, GRANT_b;
    logic [23:0] DIN_b = '0;
    logic [7:0]  TX_DATA_b;
    logic        TX_START_b, TX_BUSY_b;

    logic tx_ok = 1'b1;
    int   txc_a = 0, txc_b = 0;

    uart_tx_arbiter #(.Nreq(4), .Wdata(8)) dut_a (
        .CLK(CLK), .RST(RST), .REQ(REQ_a), .LOCK(LOCK_a), .DIN(DIN_a),
        .ACK(ACK_a), .GRANT(GRANT_a), .TX_DATA(TX_DATA_a),
        .TX_START(TX_START_a), .TX_BUSY(TX_BUSY_a)
    );

    uart_tx_arbiter #(.Nreq(3), .Wdata(8)) dut_b (
        .CLK(CLK), .RST(RST), .REQ(REQ_b), .LOCK(LOCK_b), .DIN(DIN_b),
        .ACK(ACK_b), .GRANT(GRANT_b), .TX_DATA(TX_DATA_b),
        .TX_START(TX_START_b), .TX_BUSY(TX_BUSY_b)
    );

    always #5 CLK = ~CLK;

    // TX models: busy for FRAME cycles starting the cycle after TX_START.
    always @(posedge CLK) begin
        if (TX_START_a && tx_ok) txc_a <= FRAME;
        else if (txc_a != 0)     txc_a <= txc_a - 1;
        if (TX_START_b)          txc_b <= FRAME;
        else if (txc_b != 0)     txc_b <= txc_b - 1;
    end
    assign TX_BUSY_a = (txc_a != 0);
    assign TX_BUSY_b = (txc_b != 0);

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] ack;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0, bad = 0, cyc = 0;
    int   starts_a = 0, starts_b = 0, last_a = -1, gap_a = 0, min_gap = 1000;
    int   rc_a[4], rc_b[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, score any start, retire acked requests.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (TX_START_a) begin
            starts_a++;
            if (last_a >= 0) begin
                gap_a = cyc - last_a;
                if (gap_a < min_gap) min_gap = gap_a;
            end
            last_a = cyc;
            chk("a_busy_at_start", 32'(TX_BUSY_a), 0);
            chk("a_start_expected", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_tx_data", 32'(TX_DATA_a), 32'(e.data));
                chk("a_ack", 32'(ACK_a), 32'(e.ack));
                chk("a_grant", 32'(GRANT_a), 32'(e.ack));
            end
        end else if (ACK_a != 0) begin
            chk("a_ack_outside_start", 32'(ACK_a), 0);
        end
        if (TX_START_b) begin
            starts_b++;
            chk("b_busy_at_start", 32'(TX_BUSY_b), 0);
            chk("b_start_expected", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_tx_data", 32'(TX_DATA_b), 32'(e.data));
                chk("b_ack", 32'({1'b0, ACK_b}), 32'(e.ack));
                chk("b_grant", 32'({1'b0, GRANT_b}), 32'(e.ack));
            end
        end
        for (int i = 0; i < 4; i++)
            if (ACK_a[i] && rc_a[i] > 0) begin
                rc_a[i]--;
                if (rc_a[i] == 0) REQ_a[i] = 1'b0;
            end
        for (int i = 0; i < 3; i++)
            if (ACK_b[i] && rc_b[i] > 0) begin
                rc_b[i]--;
                if (rc_b[i] == 0) REQ_b[i] = 1'b0;
            end
    endtask

    task automatic req_a(input int i, input int n, input logic [7:0] d);
        DIN_a[i*8 +: 8] = d;
        rc_a[i] = n;
        REQ_a[i] = 1'b1;
    endtask

    task automatic req_b(input int i, input logic [7:0] d);
        DIN_b[i*8 +: 8] = d;
        rc_b[i] = 1;
        REQ_b[i] = 1'b1;
    endtask

    task automatic push_a(input logic [7:0] d, input logic [3:0] ack);
        exp_t e;
        e.data = d;
        e.ack  = ack;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic [3:0] ack);
        exp_t e;
        e.data = d;
        e.ack  = ack;
        qb.push_back(e);
    endtask

    task automatic wait_busy_a(input logic lvl, input int lim);
        int n = 0;
        while (TX_BUSY_a !== lvl && n < lim) begin tick(); n++; end
        chk("wait_busy_a", 32'(TX_BUSY_a === lvl), 1);
    endtask

    task automatic wait_starts_a(input int target, input int lim);
        int n = 0;
        while (starts_a < target && n < lim) begin tick(); n++; end
        chk("wait_starts_a", starts_a, target);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!(qa.size() == 0 && qb.size() == 0 && GRANT_a == 0 && GRANT_b == 0 &&
                 !TX_BUSY_a && !TX_BUSY_b && REQ_a == 0 && REQ_b == 0) && n < lim) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(n < lim), 1);
        tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    int base, gbad, n;

    initial begin
        for (int i = 0; i < 4; i++) rc_a[i] = 0;
        for (int i = 0; i < 3; i++) rc_b[i] = 0;

        // Reset values
        do_reset();
        chk("rst_ack", 32'(ACK_a), 0);
        chk("rst_grant", 32'(GRANT_a), 0);
        chk("rst_start", 32'(TX_START_a), 0);
        chk("rst_data", 32'(TX_DATA_a), 0);

        // Single requester: start one cycle after REQ is seen
        push_a(8'h55, 4'b0001);
        req_a(0, 1, 8'h55);
        tick();
        chk("t1_latency", 32'(TX_START_a), 1);
        wait_busy_a(1'b1, 5);
        wait_busy_a(1'b0, 50);
        tick();
        chk("t1_grant_clear", 32'(GRANT_a), 0);
        wait_idle(100);

        // Fairness from ptr=0
        do_reset();
        min_gap = 1000;
        last_a  = -1;
        push_a(8'hA0, 4'b0001);
        push_a(8'hA1, 4'b0010);
        push_a(8'hA2, 4'b0100);
        push_a(8'hA3, 4'b1000);
        push_a(8'hA0, 4'b0001);
        req_a(0, 2, 8'hA0);
        req_a(1, 1, 8'hA1);
        req_a(2, 1, 8'hA2);
        req_a(3, 1, 8'hA3);
        wait_idle(500);
        chk("t2_min_gap", min_gap, FRAME + 3);

        // Lock: requester 1 keeps the line for 3 bytes, then 0
        base = starts_a;
        gbad = 0;
        LOCK_a = 4'b0010;
        push_a(8'h31, 4'b0010);
        push_a(8'h31, 4'b0010);
        push_a(8'h31, 4'b0010);
        push_a(8'h30, 4'b0001);
        req_a(1, 3, 8'h31);
        req_a(0, 1, 8'h30);
        wait_starts_a(base + 1, 20);
        n = 0;
        while (starts_a < base + 3 && n < 200) begin
            tick();
            if (GRANT_a != 4'b0010) gbad++;
            n++;
        end
        chk("t3_three_starts", starts_a, base + 3);
        wait_busy_a(1'b1, 5);
        wait_busy_a(1'b0, 50);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (GRANT_a != 4'b0010) gbad++;
        end
        chk("t3_grant_held", gbad, 0);
        chk("t3_no_start_locked", starts_a, base + 3);
        LOCK_a = 4'b0000;
        wait_starts_a(base + 4, 20);
        wait_idle(100);

        // Reset mid-frame
        base = starts_a;
        push_a(8'h42, 4'b0100);
        push_a(8'h42, 4'b0100);
        req_a(2, 2, 8'h42);
        wait_starts_a(base + 1, 20);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_busy_before_rst", 32'(TX_BUSY_a), 1);
        RST = 1'b1;
        tick();
        chk("t4_rst_ack", 32'(ACK_a), 0);
        chk("t4_rst_grant", 32'(GRANT_a), 0);
        chk("t4_rst_start", 32'(TX_START_a), 0);
        chk("t4_rst_data", 32'(TX_DATA_a), 0);
        RST = 1'b0;
        n = 0;
        while (TX_BUSY_a && n < 50) begin tick(); n++; end
        chk("t4_no_start_while_busy", starts_a, base + 1);
        wait_starts_a(base + 2, 20);
        wait_idle(100);

        // TX misses the start: retry after 2 cycles in WAIT_HI
        base = starts_a;
        tx_ok = 1'b0;
        push_a(8'h63, 4'b1000);
        push_a(8'h61, 4'b0010);
        req_a(3, 1, 8'h63);
        req_a(1, 1, 8'h61);
        wait_starts_a(base + 2, 30);
        chk("t5_retry_gap", gap_a, 4);
        tx_ok = 1'b1;
        wait_idle(100);

        // Nreq=3 wrap: ptr 2 -> requester 0, then ptr 1
        push_b(8'hB1, 4'b0010);
        req_b(1, 8'hB1);
        wait_idle(100);
        push_b(8'hB0, 4'b0001);
        req_b(0, 8'hB0);
        wait_idle(100);
        push_b(8'hB1, 4'b0010);
        push_b(8'hB2, 4'b0100);
        push_b(8'hB0, 4'b0001);
        req_b(0, 8'hB0);
        req_b(1, 8'hB1);
        req_b(2, 8'hB2);
        wait_idle(200);
        chk("t6_b_starts", starts_b, 5);

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between Nreq byte sources.
- Each requester presents a byte with REQ. The arbiter picks one, hands its byte to the TX with a one-cycle start pulse, and acknowledges the requester.
- It then waits for the TX to finish the frame before granting again.
- An optional per-requester LOCK holds the grant across multi-byte messages, so messages are not interleaved on the line.

Parameters:
- Nreq, 4, number of requesters (2..16).
- Wdata, 8, data bits per frame; must match the TX instance.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  Nreq  per-requester byte-valid; must be held until the matching ACK bit pulses.
- LOCK  input  Nreq  per-requester grant hold; sampled at end of frame.
- DIN  input  Nreq*Wdata  requester bytes; requester i occupies bits [i*Wdata +: Wdata].
- ACK  output  Nreq  one-cycle pulse; byte of requester i accepted.
- GRANT  output  Nreq  one-hot current owner; all-zero when idle.
- TX_DATA  output  Wdata  byte to TX; valid while TX_START is high.
- TX_START  output  1  one-cycle start pulse to TX.
- TX_BUSY  input  1  TX busy; high from the cycle after TX_START until the stop bit completes.

Behaviour:
- Reset values: ACK=0, GRANT=0, TX_START=0, TX_DATA=0, state=IDLE, rotation pointer ptr=0, locked=0.
- RST overrides every other input in the same edge. Reset mid-frame abandons arbiter state only; the TX finishes its frame, and IDLE will not issue while TX_BUSY=1.
- States:
  - IDLE: if TX_BUSY=0 and REQ≠0, select a winner w, set GRANT=onehot(w), latch DIN[w] into TX_DATA, go to START. Otherwise stay.
  - START (exactly one cycle): TX_START=1, ACK[w]=1, go to WAIT_HI.
  - WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO. If TX_BUSY stays 0 for 2 cycles, go to IDLE (TX missed the start; the byte is dropped, ACK has already been given).
  - WAIT_LO: on TX_BUSY=0, end of frame:
    - If LOCK[w]=1, set locked=1 and keep GRANT; otherwise set locked=0, GRANT=0, ptr=(w+1) mod Nreq.
    - Go to IDLE.
- Winner selection:
  - If locked=1: only requester w is eligible. Other REQs wait even if w is idle.
  - If locked=1 and LOCK[w] has dropped in IDLE: clear locked, apply the ptr update for w, then arbitrate normally in the same cycle.
  - Otherwise: first i with REQ[i]=1 scanning ptr, ptr+1, … wrapping at Nreq-1→0.
- Latency:
  - REQ seen in IDLE at cycle c → TX_START and ACK at cycle c+1.
  - Minimum spacing between TX_START pulses is frame length + 3 cycles.
- At most one ACK bit and one GRANT bit high at any time. ACK is high only in START.
- A REQ that drops before ACK is a protocol error. If it was already latched, the latched byte is still sent.
- REQ/LOCK changes while not in IDLE or WAIT_LO take effect only at the next decision point.
- ptr arithmetic is modulo Nreq; non-power-of-two Nreq must wrap correctly, e.g. Nreq=3 goes 2→0.

Test Plan:
- Single requester: RST, then REQ=0001, DIN[0]=0x55. Required: TX_START and ACK=0001 exactly one cycle after REQ is first seen in IDLE, TX_DATA=0x55, GRANT=0001, then GRANT=0 after TX_BUSY falls.
- Fairness: REQ=1111 held, DIN=0xA0..0xA3. Required: TX bytes A0, A1, A2, A3, A0 in that order, with no TX_START while TX_BUSY=1.
- Lock: REQ=0011, LOCK[1]=1 for 3 frames, requester 0 pending. Required: bytes 1, 1, 1 on the line, then requester 0 after LOCK[1] drops. GRANT stays 0010 throughout the lock.
- Wrap with Nreq=3: ptr=2 and REQ=001. Required: requester 0 wins. After its frame, ptr=1.
- Reset mid-frame: assert RST in WAIT_LO while TX_BUSY=1 and REQ=0100. Required: outputs go to reset values next edge, and no TX_START until TX_BUSY=0.
- TX missed start: hold TX_BUSY=0 after TX_START. Required: return to IDLE after 2 cycles, and the next pending request is served.
